fft_stream: RTL and testbench

FFT_STREAM -- requirements
Module: fft_stream

---
 rtl/fft_stream.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_stream.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream.sv
// Streaming radix-2 DIT FFT, N=4 or 8: bit-reversed load, in-place compute, natural-order unload.
// Define FFT_IFFT_EN to add the per-frame inverse input (conjugated twiddles).
module fft_stream #(
    parameter int DATA_W   = 16,
    parameter int N_POINTS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef FFT_IFFT_EN
    input  logic                     inverse,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic                     out_last,
    output logic                     busy
);

    localparam int LOG2N = (N_POINTS == 8) ? 3 : 2;
    localparam int AW    = LOG2N;
    localparam int BW    = LOG2N - 1;
    localparam int PW    = 2 * DATA_W;
    localparam int TW    = DATA_W + 2;
    localparam int SW    = DATA_W + 3;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_POINTS - 1);
    localparam logic [AW-1:0] K_ONE    = AW'(1);
    localparam logic [AW-1:0] K_NEGJ   = AW'(N_POINTS / 4);
    localparam logic [1:0]    LAST_STG = 2'(LOG2N - 1);

    localparam int C45 = int'(0.70710678 * (2.0 ** (DATA_W - 1)));
    localparam logic signed [DATA_W-1:0] WP = DATA_W'(C45);
    localparam logic signed [DATA_W-1:0] WN = DATA_W'(-C45);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    state_t state;

    logic [AW-1:0] cnt;
    logic [AW-1:0] ocnt;
    logic [1:0]    stg;
    logic [BW-1:0] bcnt;
    logic          inv;

    logic signed [DATA_W-1:0] mr [N_POINTS];
    logic signed [DATA_W-1:0] mi [N_POINTS];

`ifdef FFT_IFFT_EN
    logic inv_q;
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = x[AW-1-i];
        end
        return r;
    endfunction

    // Butterfly b of stage s: pair (a, a+2^s), twiddle k = j * N/2^(s+1).
    logic [AW-1:0] bx;
    logic [AW-1:0] hspan;
    logic [AW-1:0] jj;
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [AW-1:0] kk;

    always_comb begin
        bx    = AW'(bcnt);
        hspan = K_ONE << stg;
        jj    = bx & (hspan - K_ONE);
        ia    = ((bx >> stg) << (stg + 2'd1)) | jj;
        ib    = ia | hspan;
        kk    = jj << (LAST_STG - stg);
    end

    logic signed [DATA_W-1:0] ar, ai, br, bi;
    logic signed [DATA_W-1:0] wr, wi;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [TW-1:0]     tr, ti;
    logic signed [SW-1:0]     s0r, s0i, s1r, s1i;
    logic signed [DATA_W-1:0] nar, nai, nbr, nbi;

    always_comb begin
        ar   = mr[ia];
        ai   = mi[ia];
        br   = mr[ib];
        bi   = mi[ib];
        wr   = (kk == K_ONE) ? WP : WN;
        wi   = inv ? WP : WN;
        p_rr = PW'(br) * PW'(wr);
        p_ii = PW'(bi) * PW'(wi);
        p_ri = PW'(br) * PW'(wi);
        p_ir = PW'(bi) * PW'(wr);
        tr   = '0;
        ti   = '0;
        unique case (1'b1)
            (kk == '0): begin
                tr = TW'(br);
                ti = TW'(bi);
            end
            (kk == K_NEGJ): begin
                // -j (or +j when inverse) is a pure swap/negate.
                if (inv) begin
                    tr = -TW'(bi);
                    ti = TW'(br);
                end else begin
                    tr = TW'(bi);
                    ti = -TW'(br);
                end
            end
            default: begin
                tr = TW'(p_rr >>> (DATA_W - 1)) - TW'(p_ii >>> (DATA_W - 1));
                ti = TW'(p_ri >>> (DATA_W - 1)) + TW'(p_ir >>> (DATA_W - 1));
            end
        endcase
        s0r = SW'(ar) + SW'(tr);
        s0i = SW'(ai) + SW'(ti);
        s1r = SW'(ar) - SW'(tr);
        s1i = SW'(ai) - SW'(ti);
        nar = DATA_W'(s0r >>> 1);
        nai = DATA_W'(s0i >>> 1);
        nbr = DATA_W'(s1r >>> 1);
        nbi = DATA_W'(s1i >>> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            ocnt      <= '0;
            stg       <= '0;
            bcnt      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
`ifdef FFT_IFFT_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        mr[bitrev(cnt)] <= in_real;
                        mi[bitrev(cnt)] <= in_imag;
`ifdef FFT_IFFT_EN
                        if (cnt == '0) begin
                            inv_q <= inverse;
                        end
`endif
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            stg   <= '0;
                            bcnt  <= '0;
                            state <= COMPUTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    mr[ia] <= nar;
                    mi[ia] <= nai;
                    mr[ib] <= nbr;
                    mi[ib] <= nbi;
                    if (bcnt == '1) begin
                        bcnt <= '0;
                        if (stg == LAST_STG) begin
                            stg   <= '0;
                            ocnt  <= '0;
                            state <= UNLOAD;
                        end else begin
                            stg <= stg + 2'd1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    // One settle cycle fetches bin 0 before out_valid rises.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_real  <= mr[ocnt];
                        out_imag  <= mi[ocnt];
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            ocnt      <= '0;
                            state     <= LOAD;
                        end else begin
                            ocnt     <= ocnt + 1'b1;
                            out_real <= mr[ocnt + 1'b1];
                            out_imag <= mi[ocnt + 1'b1];
                            out_last <= ((ocnt + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stream.sv
// Scoreboard bench for fft_stream: one N=4 and one N=8 instance, directed and random frames.
module tb_fft_stream;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst       [2];
    logic                in_valid  [2];
    logic                in_ready  [2];
    logic                out_valid [2];
    logic                out_ready [2];
    logic                out_last  [2];
    logic                busy      [2];
    logic signed [W-1:0] in_re     [2];
    logic signed [W-1:0] in_im     [2];
    logic signed [W-1:0] out_re    [2];
    logic signed [W-1:0] out_im    [2];
`ifdef FFT_IFFT_EN
    logic                inv_s     [2];
`endif

    fft_stream #(.DATA_W(W), .N_POINTS(4)) u4 (
        .clk(clk),
        .reset(rst[0]),
`ifdef FFT_IFFT_EN
        .inverse(inv_s[0]),
`endif
        .in_valid(in_valid[0]),
        .in_ready(in_ready[0]),
        .in_real(in_re[0]),
        .in_imag(in_im[0]),
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .out_real(out_re[0]),
        .out_imag(out_im[0]),
        .out_last(out_last[0]),
        .busy(busy[0])
    );

    fft_stream #(.DATA_W(W), .N_POINTS(8)) u8 (
        .clk(clk),
        .reset(rst[1]),
`ifdef FFT_IFFT_EN
        .inverse(inv_s[1]),
`endif
        .in_valid(in_valid[1]),
        .in_ready(in_ready[1]),
        .in_real(in_re[1]),
        .in_imag(in_im[1]),
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .out_real(out_re[1]),
        .out_imag(out_im[1]),
        .out_last(out_last[1]),
        .busy(busy[1])
    );

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t me;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc [2];
    bit pv [2];
    bit hv [2];
    int h_re [2];
    int h_im [2];
    int h_last [2];
    int rmode [2];
    int bidx [2];
    int scnt [2];
    bit hs [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nof(input int u);
        return (u == 0) ? 4 : 8;
    endfunction

    task automatic check(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input int u, input int re, input int im, input bit last);
        exp_t e;
        e.re = re;
        e.im = im;
        e.last = last;
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic bit pop_exp(input int u, output exp_t e);
        e.re = 0;
        e.im = 0;
        e.last = 0;
        if (u == 0) begin
            if (q0.size() == 0) return 0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 0;
            e = q1.pop_front();
        end
        return 1;
    endfunction

    // Reference: bit-reverse, then per-stage butterflies with the scaled fixed-point rules.
    function automatic void model(input int n, input bit inv,
                                  input int xr[8], input int xi[8],
                                  output int yr[8], output int yi[8]);
        int lg, r, k, a, b;
        longint ar, ai, br, bi, wr, wi, tr, ti;
        real ang, sc;
        lg = (n == 8) ? 3 : 2;
        sc = 2.0 ** (W - 1);
        for (int i = 0; i < 8; i++) begin
            yr[i] = 0;
            yi[i] = 0;
        end
        for (int i = 0; i < n; i++) begin
            r = 0;
            for (int q = 0; q < lg; q++)
                if (((i >> q) & 1) == 1) r = r | (1 << (lg - 1 - q));
            yr[r] = xr[i];
            yi[r] = xi[i];
        end
        for (int h = 1; h < n; h = h * 2)
            for (int g = 0; g < n; g = g + 2 * h)
                for (int j = 0; j < h; j++) begin
                    k = j * (n / (2 * h));
                    a = g + j;
                    b = a + h;
                    ar = yr[a];
                    ai = yi[a];
                    br = yr[b];
                    bi = yi[b];
                    if (k == 0) begin
                        tr = br;
                        ti = bi;
                    end else if (4 * k == n) begin
                        tr = inv ? -bi : bi;
                        ti = inv ? br : -br;
                    end else begin
                        ang = 2.0 * 3.14159265358979 * k / n;
                        wr = longint'(sc * $cos(ang));
                        wi = longint'(-sc * $sin(ang));
                        if (inv) wi = -wi;
                        tr = ((br * wr) >>> (W - 1)) - ((bi * wi) >>> (W - 1));
                        ti = ((br * wi) >>> (W - 1)) + ((bi * wr) >>> (W - 1));
                    end
                    yr[a] = int'((ar + tr) >>> 1);
                    yi[a] = int'((ai + ti) >>> 1);
                    yr[b] = int'((ar - tr) >>> 1);
                    yi[b] = int'((ai - ti) >>> 1);
                end
    endfunction

    task automatic send_frame(input int u, input int xr[8], input int xi[8],
                              input bit inv, input bit gaps);
        bit acc;
        for (int i = 0; i < nof(u); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid[u] = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid[u] = 1'b1;
            in_re[u] = W'(xr[i]);
            in_im[u] = W'(xi[i]);
`ifdef FFT_IFFT_EN
            inv_s[u] = (i == 0) ? inv : ~inv;
`else
            if (inv) $display("inverse requested without FFT_IFFT_EN");
`endif
            acc = 1'b0;
            for (int w = 0; w < 300 && !acc; w++) begin
                acc = in_ready[u];
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout u%0d: sample %0d not accepted, required accept", u, i);
                in_valid[u] = 1'b0;
                return;
            end
        end
        last_acc[u] = cyc;
        in_valid[u] = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 3000 && (q0.size() + q1.size()) > 0; w++)
            @(posedge clk);
        #1;
        check("drain_pending_bins", q0.size() + q1.size(), 0);
    endtask

    // Monitor: scoreboard pops, stall stability, latency, load/unload exclusion.
    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst[u] !== 1'b0) begin
                    pv[u] = 0;
                    hv[u] = 0;
                end else begin
                    if (out_valid[u] && !pv[u])
                        check($sformatf("valid_latency_u%0d", u), cyc - last_acc[u],
                              (u == 0) ? 5 : 13);
                    pv[u] = out_valid[u];
                    if (out_valid[u]) begin
                        check($sformatf("in_ready_in_unload_u%0d", u), int'(in_ready[u]), 0);
                        check($sformatf("busy_in_unload_u%0d", u), int'(busy[u]), 1);
                        if (hv[u]) begin
                            check($sformatf("stall_hold_re_u%0d", u), int'(out_re[u]), h_re[u]);
                            check($sformatf("stall_hold_im_u%0d", u), int'(out_im[u]), h_im[u]);
                            check($sformatf("stall_hold_last_u%0d", u), int'(out_last[u]), h_last[u]);
                        end
                        if (out_ready[u]) begin
                            hv[u] = 0;
                            if (pop_exp(u, me)) begin
                                check($sformatf("bin_re_u%0d", u), int'(out_re[u]), me.re);
                                check($sformatf("bin_im_u%0d", u), int'(out_im[u]), me.im);
                                check($sformatf("bin_last_u%0d", u), int'(out_last[u]), int'(me.last));
                            end else begin
                                tests++;
                                fails++;
                                $display("FAIL unexpected_bin_u%0d: got (%0d,%0d), required no bin",
                                         u, out_re[u], out_im[u]);
                            end
                        end else begin
                            hv[u] = 1;
                            h_re[u] = int'(out_re[u]);
                            h_im[u] = int'(out_im[u]);
                            h_last[u] = int'(out_last[u]);
                        end
                    end else begin
                        hv[u] = 0;
                    end
                end
            end
        end
    end

    // Downstream ready: always, random, or a 3-cycle stall on bin 2.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                if (hs[u]) bidx[u] = (bidx[u] + 1) % nof(u);
                case (rmode[u])
                    1: out_ready[u] = ($urandom_range(0, 2) != 0);
                    2: begin
                        if (out_valid[u] && bidx[u] == 2 && scnt[u] < 3) begin
                            out_ready[u] = 1'b0;
                            scnt[u]++;
                        end else begin
                            out_ready[u] = 1'b1;
                        end
                    end
                    default: out_ready[u] = 1'b1;
                endcase
                hs[u] = out_valid[u] && out_ready[u];
            end
        end
    end

    int xr [8];
    int xi [8];
    int yr [8];
    int yi [8];
    int u;
    bit inv;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            in_valid[k] = 1'b0;
            in_re[k] = '0;
            in_im[k] = '0;
            out_ready[k] = 1'b1;
            rmode[k] = 0;
            bidx[k] = 0;
            scnt[k] = 0;
            hs[k] = 0;
            pv[k] = 0;
            hv[k] = 0;
            last_acc[k] = 0;
`ifdef FFT_IFFT_EN
            inv_s[k] = 1'b0;
`endif
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_in_ready_u%0d", k), int'(in_ready[k]), 1);
            check($sformatf("rst_out_valid_u%0d", k), int'(out_valid[k]), 0);
            check($sformatf("rst_out_last_u%0d", k), int'(out_last[k]), 0);
            check($sformatf("rst_busy_u%0d", k), int'(busy[k]), 0);
            check($sformatf("rst_out_re_u%0d", k), int'(out_re[k]), 0);
            check($sformatf("rst_out_im_u%0d", k), int'(out_im[k]), 0);
            rst[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Ramp 1,2,3,4
        xr = '{1, 2, 3, 4, 0, 0, 0, 0};
        xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_exp(0, 2, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, -1, 1);
        send_frame(0, xr, xi, 0, 0);
        drain();

        // Impulse
        xr = '{16384, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) push_exp(0, 4096, 0, i == 3);
        send_frame(0, xr, xi, 0, 0);
        drain();

        // DC on N=8
        xr = '{800, 800, 800, 800, 800, 800, 800, 800};
        push_exp(1, 800, 0, 0);
        for (int i = 1; i < 8; i++) push_exp(1, 0, 0, i == 7);
        send_frame(1, xr, xi, 0, 0);
        drain();

        // Ramp with a 3-cycle stall on bin 2
        xr = '{1, 2, 3, 4, 0, 0, 0, 0};
        rmode[0] = 2;
        scnt[0] = 0;
        push_exp(0, 2, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, -1, 1);
        send_frame(0, xr, xi, 0, 0);
        drain();
        check("stall_cycles_seen", scnt[0], 3);
        rmode[0] = 0;

        // Reset at compute cycle 2, then a fresh ramp
        send_frame(0, xr, xi, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_mid_compute", int'(busy[0]), 1);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check("midrst_in_ready", int'(in_ready[0]), 1);
        check("midrst_out_valid", int'(out_valid[0]), 0);
        check("midrst_busy", int'(busy[0]), 0);
        push_exp(0, 2, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, 0, 0);
        push_exp(0, -1, -1, 1);
        send_frame(0, xr, xi, 0, 0);
        drain();

`ifdef FFT_IFFT_EN
        xr = '{0, 4096, 0, 0, 0, 0, 0, 0};
        push_exp(0, 1024, 0, 0);
        push_exp(0, 0, -1024, 0);
        push_exp(0, -1024, 0, 0);
        push_exp(0, 0, 1024, 1);
        send_frame(0, xr, xi, 0, 0);
        drain();
        push_exp(0, 1024, 0, 0);
        push_exp(0, 0, 1024, 0);
        push_exp(0, -1024, 0, 0);
        push_exp(0, 0, -1024, 1);
        send_frame(0, xr, xi, 1, 0);
        drain();
`endif

        // Random frames, random gaps and backpressure, checked against the model
        rmode[0] = 1;
        rmode[1] = 1;
        for (int f = 0; f < 30; f++) begin
            u = f % 2;
            for (int i = 0; i < 8; i++) begin
                xr[i] = int'($urandom_range(0, 32767)) - 16384;
                xi[i] = int'($urandom_range(0, 32767)) - 16384;
            end
`ifdef FFT_IFFT_EN
            inv = 1'($urandom_range(0, 1));
`else
            inv = 1'b0;
`endif
            model(nof(u), inv, xr, xi, yr, yi);
            for (int i = 0; i < nof(u); i++) push_exp(u, yr[i], yi[i], i == nof(u) - 1);
            send_frame(u, xr, xi, inv, 1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
